batcharger_ctrl: RTL and testbench

Digital charge controller for the 64-bit battery charger macro. It consumes sampled ADC codes of battery voltage, battery current and battery temperature, and sequences the charge through trickle (TC), constant-current (CC) and constant-voltage (CV) modes. It drives the current-DAC code and the `tc`/`cc`/`cv` mode flags that the analog charger core uses to set `iforcedbat`.

---
 rtl/batcharger_pkg.sv | 17 +
 rtl/batcharger_if.sv | 14 +
 rtl/batcharger_filt.sv | 36 +++
 rtl/batcharger_ctrl.sv | 151 +++++++++++++++
 tb/tb_batcharger_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/batcharger_pkg.sv
// Shared types and constants for the battery charge controller.
package batcharger_pkg;

   // Charge sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TC   = 3'd1,
      ST_CC   = 3'd2,
      ST_CV   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // icc = sel << ICC_SHIFT, itc = icc >> ITC_SHIFT.
   localparam int ICC_SHIFT = 4;
   localparam int ITC_SHIFT = 3;

endpackage : batcharger_pkg

// File: rtl/batcharger_if.sv
// Sampled ADC bus: one-cycle valid strobe with the three battery codes.
interface batcharger_if #(
   parameter int ADC_W = 8
);
   logic             adc_valid;
   logic [ADC_W-1:0] vbat;
   logic [ADC_W-1:0] ibat;
   logic [ADC_W-1:0] vtemp;

   // The ADC front end drives the bus.
   modport master (output adc_valid, vbat, ibat, vtemp);
   // The charge controller consumes it.
   modport slave  (input  adc_valid, vbat, ibat, vtemp);
endinterface : batcharger_if

// File: rtl/batcharger_filt.sv
// Consecutive-sample qualifier: fire on the NFILT-th valid sample in a row
// on which the pending transition condition holds. Shared by all states,
// since only one transition is ever pending at a time.
module batcharger_filt #(
   parameter int NFILT = 2
) (
   input  logic clk,
   input  logic rstz,
   input  logic cond,
   input  logic adc_valid,
   input  logic clr,
   output logic fire
);

   // The count never exceeds NFILT-1: firing always changes state, which clears it.
   localparam int              CNT_W = (NFILT > 1) ? $clog2(NFILT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NFILT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Not gated by clr on purpose: clr is derived from the next state, which uses fire.
   assign fire = adc_valid && cond && (cnt_q == LAST);

   // Count qualifying samples; a failing sample or a clear restarts the run.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (adc_valid) begin
         if (!cond || fire) cnt_q <= '0;
         else               cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule : batcharger_filt

// File: rtl/batcharger_ctrl.sv
// Charge controller: sequences trickle, constant-current and constant-voltage
// charging from sampled battery voltage/current/temperature codes and drives
// the current-DAC code plus the one-hot mode flags. All outputs are registered.
module batcharger_ctrl
   import batcharger_pkg::*;
#(
   parameter int ADC_W = 8,
   parameter int NFILT = 2,
   parameter int TMR_W = 16
) (
   input  logic             clk,
   input  logic             rstz,
   input  logic             en,
   input  logic [3:0]       sel,
   batcharger_if.slave      adc_bus,
   input  logic [ADC_W-1:0] vcutoff,
   input  logic [ADC_W-1:0] vpreset,
   input  logic [ADC_W-1:0] vrech,
   input  logic [ADC_W-1:0] iend,
   input  logic [ADC_W-1:0] tempmin,
   input  logic [ADC_W-1:0] tempmax,
   input  logic [TMR_W-1:0] cv_tmax,
   output logic [ADC_W-1:0] idac,
   output logic             tc,
   output logic             cc,
   output logic             cv,
   output logic             done,
   output logic             tfault
);

   state_e           state_q;
   state_e           state_d;
   state_e           tgt;
   logic             temp_ok;
   logic             charging;
   logic             fault_hit;
   logic             cond;
   logic             fire;
   logic             filt_clr;
   logic [TMR_W-1:0] cv_tmr_q;
   logic [ADC_W-1:0] icc;
   logic [ADC_W-1:0] itc;

   // Charge current codes follow sel; the cast truncates or zero-extends to ADC_W.
   assign icc = ADC_W'(32'(sel) << ICC_SHIFT);
   assign itc = icc >> ITC_SHIFT;

   // Temperature window check and the unfiltered over/under-temperature abort.
   always_comb begin
      temp_ok   = (adc_bus.vtemp >= tempmin) && (adc_bus.vtemp <= tempmax);
      charging  = (state_q == ST_TC) || (state_q == ST_CC) || (state_q == ST_CV);
      fault_hit = adc_bus.adc_valid && charging && !temp_ok;
   end

   // Pending transition condition and its destination for the current state.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      cond = 1'b0;
      tgt  = state_q;
      unique case (state_q)
         ST_IDLE: begin
            // Enable is handled by the override path; here only temperature gates entry.
            cond = temp_ok;
            if (adc_bus.vbat < vcutoff)      tgt = ST_TC;
            else if (adc_bus.vbat < vpreset) tgt = ST_CC;
            else                             tgt = ST_DONE;
         end
         ST_TC: begin
            cond = (adc_bus.vbat >= vcutoff);
            tgt  = ST_CC;
         end
         ST_CC: begin
            cond = (adc_bus.vbat >= vpreset);
            tgt  = ST_CV;
         end
         ST_CV: begin
            // The timeout is filtered too, so DONE lands NFILT samples after saturation.
            cond = (adc_bus.ibat < iend) || (cv_tmr_q == cv_tmax);
            tgt  = ST_DONE;
         end
         ST_DONE: begin
            cond = (adc_bus.vbat < vrech);
            tgt  = ST_CC;
         end
         default: ;
      endcase
   end

   batcharger_filt #(
      .NFILT (NFILT)
   ) u_filt (
      .clk       (clk),
      .rstz      (rstz),
      .cond      (cond),
      .adc_valid (adc_bus.adc_valid),
      .clr       (filt_clr),
      .fire      (fire)
   );

   // Next state: enable drop beats temperature fault beats a filtered transition.
   always_comb begin
      state_d = state_q;
      if (!en)            state_d = ST_IDLE;
      else if (fault_hit) state_d = ST_IDLE;
      else if (fire)      state_d = tgt;
   end

   assign filt_clr = !en || (state_d != state_q);

   // State register.
   always_ff @(posedge clk or negedge rstz) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rstz) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Temperature pause flag: set on abort, cleared by an in-window sample or enable drop.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz)                               tfault <= 1'b0;
      else if (!en)                            tfault <= 1'b0;
      else if (fault_hit)                      tfault <= 1'b1;
      else if (adc_bus.adc_valid && temp_ok)   tfault <= 1'b0;
   end

   // CV timeout counter: held at zero outside CV, counts valid samples in CV, saturates.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz)                                            cv_tmr_q <= '0;
      else if (state_q != ST_CV)                            cv_tmr_q <= '0;
      else if (adc_bus.adc_valid && (cv_tmr_q != cv_tmax))  cv_tmr_q <= cv_tmr_q + 1'b1;
   end

   // Registered output decode of the current state; idac tracks sel without a state change.
   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         idac <= '0;
         tc   <= 1'b0;
         cc   <= 1'b0;
         cv   <= 1'b0;
         done <= 1'b0;
      end else begin
         tc   <= (state_q == ST_TC);
         cc   <= (state_q == ST_CC);
         cv   <= (state_q == ST_CV);
         done <= (state_q == ST_DONE);
         if (state_q == ST_TC)                             idac <= itc;
         else if ((state_q == ST_CC) || (state_q == ST_CV)) idac <= icc;
         else                                               idac <= '0;
      end
   end

endmodule : batcharger_ctrl

// File: tb/tb_batcharger_ctrl.sv
// Self-checking bench for batcharger_ctrl: a sample-level charge model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_batcharger_ctrl;

   localparam int ADC_W = 8;
   localparam int NFILT = 2;
   localparam int TMR_W = 16;

   // Bench-side charge phases.
   localparam int M_OFF     = 0;
   localparam int M_TRICKLE = 1;
   localparam int M_CONST_I = 2;
   localparam int M_CONST_V = 3;
   localparam int M_FULL    = 4;

   logic             clk     = 1'b0;
   logic             rstz    = 1'b0;
   logic             en      = 1'b0;
   logic [3:0]       sel     = 4'd1;
   logic [ADC_W-1:0] vcutoff = 8'h80;
   logic [ADC_W-1:0] vpreset = 8'hD0;
   logic [ADC_W-1:0] vrech   = 8'hC0;
   logic [ADC_W-1:0] iend    = 8'h08;
   logic [ADC_W-1:0] tempmin = 8'h20;
   logic [ADC_W-1:0] tempmax = 8'hE0;
   logic [TMR_W-1:0] cv_tmax = 16'd1000;
   logic [ADC_W-1:0] idac;
   logic             tc, cc, cv, done, tfault;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   // Model state and expected outputs.
   int m_mode, m_run, m_timer;
   bit m_fault;
   int e_idac;
   bit e_tc, e_cc, e_cv, e_done;

   batcharger_if #(.ADC_W(ADC_W)) adc_bus ();

   batcharger_ctrl #(
      .ADC_W (ADC_W),
      .NFILT (NFILT),
      .TMR_W (TMR_W)
   ) dut (
      .clk     (clk),
      .rstz    (rstz),
      .en      (en),
      .sel     (sel),
      .adc_bus (adc_bus),
      .vcutoff (vcutoff),
      .vpreset (vpreset),
      .vrech   (vrech),
      .iend    (iend),
      .tempmin (tempmin),
      .tempmax (tempmax),
      .cv_tmax (cv_tmax),
      .idac    (idac),
      .tc      (tc),
      .cc      (cc),
      .cv      (cv),
      .done    (done),
      .tfault  (tfault)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_OFF;
      m_run   = 0;
      m_timer = 0;
      m_fault = 1'b0;
      e_idac  = 0;
      e_tc    = 1'b0;
      e_cc    = 1'b0;
      e_cv    = 1'b0;
      e_done  = 1'b0;
   endtask

   // One clock edge of the charge rules, at the level of whole samples.
   task automatic model_step();
      int icc;
      int tgt;
      bit tok;
      bit charging;
      bit cond;
      // Outputs show the phase held before this edge.
      icc    = int'(sel) * 16;
      e_tc   = (m_mode == M_TRICKLE);
      e_cc   = (m_mode == M_CONST_I);
      e_cv   = (m_mode == M_CONST_V);
      e_done = (m_mode == M_FULL);
      if (m_mode == M_TRICKLE)                              e_idac = icc / 8;
      else if (m_mode == M_CONST_I || m_mode == M_CONST_V)  e_idac = icc;
      else                                                  e_idac = 0;

      if (!en) begin
         m_mode  = M_OFF;
         m_run   = 0;
         m_timer = 0;
         m_fault = 1'b0;
      end else if (adc_bus.adc_valid) begin
         tok      = (adc_bus.vtemp >= tempmin) && (adc_bus.vtemp <= tempmax);
         charging = (m_mode == M_TRICKLE) || (m_mode == M_CONST_I) || (m_mode == M_CONST_V);
         if (tok) m_fault = 1'b0;
         if (charging && !tok) begin
            m_mode  = M_OFF;
            m_fault = 1'b1;
            m_run   = 0;
            m_timer = 0;
         end else begin
            cond = 1'b0;
            tgt  = m_mode;
            case (m_mode)
               M_OFF: begin
                  cond = tok;
                  if (adc_bus.vbat < vcutoff)      tgt = M_TRICKLE;
                  else if (adc_bus.vbat < vpreset) tgt = M_CONST_I;
                  else                             tgt = M_FULL;
               end
               M_TRICKLE: begin
                  cond = (adc_bus.vbat >= vcutoff);
                  tgt  = M_CONST_I;
               end
               M_CONST_I: begin
                  cond = (adc_bus.vbat >= vpreset);
                  tgt  = M_CONST_V;
               end
               M_CONST_V: begin
                  cond = (adc_bus.ibat < iend) || (m_timer == int'(cv_tmax));
                  tgt  = M_FULL;
               end
               M_FULL: begin
                  cond = (adc_bus.vbat < vrech);
                  tgt  = M_CONST_I;
               end
               default: ;
            endcase
            if (m_mode == M_CONST_V && m_timer < int'(cv_tmax)) m_timer++;
            m_run = cond ? m_run + 1 : 0;
            if (m_run >= NFILT) begin
               m_mode  = tgt;
               m_run   = 0;
               m_timer = 0;
            end
         end
      end
   endtask

   // Model follows the clock and the asynchronous reset.
   always @(posedge clk or negedge rstz) begin
      if (!rstz) model_reset();
      else       model_step();
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (cmp_on) begin
         check("cyc_idac",   idac,   e_idac);
         check("cyc_tc",     tc,     e_tc);
         check("cyc_cc",     cc,     e_cc);
         check("cyc_cv",     cv,     e_cv);
         check("cyc_done",   done,   e_done);
         check("cyc_tfault", tfault, m_fault);
      end
   end

   // One valid sample presented at exactly one active edge.
   task automatic sample(input int vb, input int ib, input int vt);
      adc_bus.vbat      = 8'(vb);
      adc_bus.ibat      = 8'(ib);
      adc_bus.vtemp     = 8'(vt);
      adc_bus.adc_valid = 1'b1;
      @(posedge clk);
      #1;
      adc_bus.adc_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      adc_bus.adc_valid = 1'b0;
      adc_bus.vbat      = '0;
      adc_bus.ibat      = 8'h40;
      adc_bus.vtemp     = 8'h80;

      // Reset state.
      idle(3);
      check("rst_idac", idac, 0);
      check("rst_tc", tc, 0);
      check("rst_cc", cc, 0);
      check("rst_cv", cv, 0);
      check("rst_done", done, 0);
      check("rst_tfault", tfault, 0);
      cmp_on = 1'b1;
      rstz   = 1'b1;
      idle(1);

      // IDLE -> TC after two qualifying samples.
      en  = 1'b1;
      sel = 4'd1;
      sample(8'h40, 8'h40, 8'h80);
      idle(1);
      check("tc_one_sample", tc, 0);
      sample(8'h40, 8'h40, 8'h80);
      idle(1);
      check("tc_entry", tc, 1);
      check("tc_idac", idac, 8'h02);

      // A single sample over vcutoff is ignored; two in a row move to CC.
      sample(8'h90, 8'h40, 8'h80);
      sample(8'h70, 8'h40, 8'h80);
      idle(2);
      check("tc_glitch_hold", tc, 1);
      sample(8'h85, 8'h40, 8'h80);
      sample(8'h88, 8'h40, 8'h80);
      idle(1);
      check("cc_entry", cc, 1);
      check("cc_idac", idac, 8'h10);

      // CC -> CV with one interrupted run.
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hC0, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("cv_entry", cv, 1);

      // CV -> DONE on low current; ibat equal to iend does not qualify.
      sample(8'hD8, 8'h04, 8'h80);
      sample(8'hD8, 8'h08, 8'h80);
      sample(8'hD8, 8'h04, 8'h80);
      idle(1);
      check("cv_iend_boundary", cv, 1);
      sample(8'hD8, 8'h04, 8'h80);
      idle(1);
      check("done_low_i", done, 1);
      check("done_idac", idac, 0);

      // DONE: vbat equal to vrech holds, below vrech goes to CC.
      sample(8'hC0, 8'h40, 8'h80);
      sample(8'hC0, 8'h40, 8'h80);
      idle(1);
      check("done_vrech_boundary", done, 1);
      sample(8'hB0, 8'h40, 8'h80);
      sample(8'hB0, 8'h40, 8'h80);
      idle(1);
      check("recharge_cc", cc, 1);

      // CV timeout with cv_tmax=10: timer saturates after 10 samples, filter needs 2 more.
      cv_tmax = 16'd10;
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("cv_entry_tmr", cv, 1);
      repeat (11) sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("cv_before_timeout", cv, 1);
      sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("done_timeout", done, 1);
      cv_tmax = 16'd1000;

      // Back to CC; temperature exactly at the window edges is allowed.
      sample(8'hB0, 8'h40, 8'h80);
      sample(8'hB0, 8'h40, 8'h80);
      sample(8'hB0, 8'h40, 8'hE0);
      sample(8'hB0, 8'h40, 8'h20);
      idle(1);
      check("cc_temp_edges", cc, 1);
      check("cc_temp_edges_tfault", tfault, 0);

      // Over-temperature in CC aborts to IDLE immediately.
      sample(8'hB0, 8'h40, 8'hF0);
      check("fault_set", tfault, 1);
      idle(1);
      check("fault_cc_off", cc, 0);
      check("fault_idac", idac, 0);
      sample(8'hB0, 8'h40, 8'hF0);
      check("fault_held", tfault, 1);
      sample(8'hB0, 8'h40, 8'h80);
      check("fault_clear", tfault, 0);
      sample(8'hB0, 8'h40, 8'h80);
      idle(1);
      check("fault_resume_cc", cc, 1);

      // Fault and a due transition on the same sample: fault wins.
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h10);
      idle(1);
      check("fault_beats_cv", cv, 0);
      check("fault_beats_tfault", tfault, 1);
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("idle_to_done", done, 1);

      // sel change mid-charge.
      sample(8'hB0, 8'h40, 8'h80);
      sample(8'hB0, 8'h40, 8'h80);
      idle(1);
      sel = 4'hF;
      idle(1);
      check("sel_f_idac", idac, 8'hF0);
      sel = 4'h3;
      idle(1);
      check("sel_3_idac", idac, 8'h30);

      // Enable drop in CV: state first, outputs one edge later.
      sample(8'hD8, 8'h40, 8'h80);
      sample(8'hD8, 8'h40, 8'h80);
      idle(1);
      check("cv_before_en", cv, 1);
      en = 1'b0;
      idle(1);
      check("cv_lag_en_low", cv, 1);
      idle(1);
      check("cv_off_en_low", cv, 0);
      check("idac_off_en_low", idac, 0);

      // Re-enable into TC with sel=3; then en=0 coincides with a firing sample.
      en = 1'b1;
      sample(8'h40, 8'h40, 8'h80);
      sample(8'h40, 8'h40, 8'h80);
      idle(1);
      check("tc_sel3", tc, 1);
      check("tc_sel3_idac", idac, 8'h06);
      sample(8'h90, 8'h40, 8'h80);
      en = 1'b0;
      sample(8'h90, 8'h40, 8'h80);
      idle(1);
      check("en_beats_valid_cc", cc, 0);
      check("en_beats_valid_tc", tc, 0);

      // Asynchronous reset mid-CC.
      en = 1'b1;
      sample(8'hB0, 8'h40, 8'h80);
      sample(8'hB0, 8'h40, 8'h80);
      idle(1);
      check("cc_before_rst", cc, 1);
      #2;
      rstz = 1'b0;
      #1;
      check("async_rst_cc", cc, 0);
      check("async_rst_idac", idac, 0);
      @(posedge clk);
      #1;
      rstz = 1'b1;
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_batcharger_ctrl
